// File: rtl/memory_cycle_pkg.sv
// -----------------------------------------------------------------------------
// memory_cycle_pkg
//   Shared definitions for the memory stage of the 16-bit pipeline:
//   datapath / register-index widths and the memory-stage FSM state encoding.
// -----------------------------------------------------------------------------
package memory_cycle_pkg;

    localparam int DATA_W = 16;   // datapath and address width
    localparam int RD_W   = 4;    // register-index width

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

endpackage : memory_cycle_pkg

// File: rtl/memory_cycle.sv
// -----------------------------------------------------------------------------
// memory_cycle
//   Memory stage of the 16-bit pipeline, between execute_cycle and writeback.
//   ALU results pass through with one cycle of latency. Loads and stores are
//   issued on a req/ack data-memory bus with variable latency; upstream stages
//   are stalled while an access is outstanding. The writeback result (ALU
//   result, load data, or the store address) and its destination register are
//   registered.
//
//   Optional feature: define MEMCYCLE_TIMEOUT_EN to abort accesses that get no
//   ack within TIMEOUT_CYCLES ACCESS cycles and raise a sticky timeout_err.
//   Without it, ACCESS waits indefinitely and timeout_err is tied low.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   asynchronous, active-high reset
//   aluout       in   ALU result; memory address for loads/stores
//   bout         in   store data
//   rdout        in   destination register
//   memread      in   instruction is a load
//   memwrite     in   instruction is a store (wins when memread is also high)
//   regwrite     in   instruction writes a register
//   mem_req      out  bus request (registered)
//   mem_we       out  1 = write, 0 = read; valid with mem_req
//   mem_addr     out  latched access address
//   mem_wdata    out  latched store data
//   mem_rdata    in   read data, valid with mem_ack
//   mem_ack      in   access complete, one-cycle pulse
//   stall        out  freeze execute_cycle and earlier stages (combinational)
//   wb_data      out  writeback data
//   wb_rd        out  writeback destination register
//   wb_regwrite  out  writeback enable
//   timeout_err  out  sticky bus-timeout flag
// -----------------------------------------------------------------------------
module memory_cycle
    import memory_cycle_pkg::*;
#(
`ifdef MEMCYCLE_TIMEOUT_EN
    parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] aluout,
    input  logic [DATA_W-1:0] bout,
    input  logic [RD_W-1:0]   rdout,
    input  logic              memread,
    input  logic              memwrite,
    input  logic              regwrite,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall,
    output logic [DATA_W-1:0] wb_data,
    output logic [RD_W-1:0]   wb_rd,
    output logic              wb_regwrite,
    output logic              timeout_err
);

    state_t            state;
    logic              mem_op;       // current input instruction touches memory
    logic              abort;        // timeout fires in this ACCESS cycle
    logic [RD_W-1:0]   op_rd;        // latched destination of the in-flight op
    logic              op_regwrite;  // latched regwrite of the in-flight op
    logic              op_load;      // in-flight op is a load (else store)

    assign mem_op = memread | memwrite;

`ifdef MEMCYCLE_TIMEOUT_EN
    // Abort on the ACCESS cycle that would bring the wait count to
    // TIMEOUT_CYCLES, so exactly TIMEOUT_CYCLES ACCESS cycles elapse.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] to_cnt;
    assign abort = (state == ST_ACCESS) && !mem_ack && (to_cnt == TO_LAST);
`else
    assign abort       = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Stall drops in the ack (or abort) cycle so the next instruction is
    // presented in the following cycle and accesses never overlap.
    assign stall = ((state == ST_IDLE) && mem_op) ||
                   ((state == ST_ACCESS) && !mem_ack && !abort);

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent logic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the op-latch registers are reset too; they are few and
            // this keeps post-reset simulation free of X on the bus outputs.
            state       <= ST_IDLE;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            wb_data     <= '0;
            wb_rd       <= '0;
            wb_regwrite <= 1'b0;
            op_rd       <= '0;
            op_regwrite <= 1'b0;
            op_load     <= 1'b0;
`ifdef MEMCYCLE_TIMEOUT_EN
            to_cnt      <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mem_op) begin
                        // Launch the access; writeback gets a bubble.
                        mem_addr    <= aluout;
                        mem_wdata   <= bout;
                        mem_we      <= memwrite;
                        mem_req     <= 1'b1;
                        op_rd       <= rdout;
                        op_regwrite <= regwrite;
                        op_load     <= !memwrite;
                        wb_regwrite <= 1'b0;
                        state       <= ST_ACCESS;
`ifdef MEMCYCLE_TIMEOUT_EN
                        to_cnt      <= '0;
`endif
                    end else begin
                        wb_data     <= aluout;
                        wb_rd       <= rdout;
                        wb_regwrite <= regwrite;
                    end
                end

                ST_ACCESS: begin
                    if (mem_ack) begin
                        mem_req     <= 1'b0;
                        state       <= ST_IDLE;
                        wb_data     <= op_load ? mem_rdata : mem_addr;
                        wb_rd       <= op_rd;
                        wb_regwrite <= op_regwrite;
                    end else if (abort) begin
                        mem_req     <= 1'b0;
                        state       <= ST_IDLE;
                        wb_regwrite <= 1'b0;
`ifdef MEMCYCLE_TIMEOUT_EN
                        timeout_err <= 1'b1;
`endif
                    end else begin
                        wb_regwrite <= 1'b0;
`ifdef MEMCYCLE_TIMEOUT_EN
                        to_cnt      <= to_cnt + 8'd1;
`endif
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule : memory_cycle

// File: tb/tb_memory_cycle.sv
// -----------------------------------------------------------------------------
// tb_memory_cycle
//   Self-checking bench for memory_cycle. Instructions are issued at the
//   transaction level; a reference memory and a pending-writeback record give
//   the expected outputs, which one compare process checks every cycle.
// -----------------------------------------------------------------------------
module tb_memory_cycle;
    import memory_cycle_pkg::*;

`ifdef MEMCYCLE_TIMEOUT_EN
    localparam int TO      = 4;
    localparam int MAX_DLY = 2;
`else
    localparam int MAX_DLY = 6;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] aluout, bout, mem_addr, mem_wdata, mem_rdata, wb_data;
    logic [RD_W-1:0]   rdout, wb_rd;
    logic              memread, memwrite, regwrite, mem_req, mem_we, mem_ack;
    logic              stall, wb_regwrite, timeout_err;

    always #5 clk = ~clk;

`ifdef MEMCYCLE_TIMEOUT_EN
    memory_cycle #(.TIMEOUT_CYCLES(TO)) dut (
`else
    memory_cycle dut (
`endif
        .clk(clk), .rst(rst), .aluout(aluout), .bout(bout), .rdout(rdout),
        .memread(memread), .memwrite(memwrite), .regwrite(regwrite),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall(stall), .wb_data(wb_data), .wb_rd(wb_rd),
        .wb_regwrite(wb_regwrite), .timeout_err(timeout_err)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference memory (model) and the bus slave's memory, both 16 words.
    logic [DATA_W-1:0] ref_mem   [16];
    logic [DATA_W-1:0] slave_mem [16];

    // Pending writeback: the instruction that completes at the coming edge.
    logic              pend_valid = 1'b0, pend_rw;
    logic [DATA_W-1:0] pend_data;
    logic [RD_W-1:0]   pend_rd;

    // Expectations for the current cycle.
    logic              check_en = 1'b0;
    logic              exp_stall, exp_req, exp_we, exp_terr = 1'b0;
    logic [DATA_W-1:0] exp_addr, exp_wdata, exp_wb_data;
    logic              exp_wb_valid, exp_wb_rw;
    logic [RD_W-1:0]   exp_wb_rd;

    int                stall_cnt = 0;
    logic              seen_we;
    logic [DATA_W-1:0] seen_wdata;

    always @(negedge clk) begin
        if (check_en) begin
            check("stall", stall, exp_stall);
            check("mem_req", mem_req, exp_req);
            if (exp_req) begin
                check("mem_we", mem_we, exp_we);
                check("mem_addr", mem_addr, exp_addr);
                check("mem_wdata", mem_wdata, exp_wdata);
                seen_we    = mem_we;
                seen_wdata = mem_wdata;
            end
            check("wb_regwrite", wb_regwrite, exp_wb_valid & exp_wb_rw);
            if (exp_wb_valid) begin
                check("wb_data", wb_data, exp_wb_data);
                check("wb_rd", wb_rd, exp_wb_rd);
            end
            check("timeout_err", timeout_err, exp_terr);
            if (stall) stall_cnt++;
        end
    end

    // Issue one instruction and run it to completion. dly = ACCESS cycle
    // index carrying the ack; dly < 0 means never ack (timeout build only).
    task automatic do_instr(input logic ld, input logic st, input logic [DATA_W-1:0] a,
                            input logic [DATA_W-1:0] b, input logic [RD_W-1:0] rd,
                            input logic rw, input int dly, input logic stray);
        logic is_mem, ack_now, to_now, done, acked;
        int   i;
        is_mem   = ld | st;
        aluout   = a;  bout = b;  rdout = rd;
        memread  = ld; memwrite = st; regwrite = rw;
        mem_ack  = stray;
        mem_rdata = 16'($urandom);
        exp_wb_valid = pend_valid; exp_wb_rw = pend_rw;
        exp_wb_data  = pend_data;  exp_wb_rd = pend_rd;
        exp_stall = is_mem;
        exp_req   = 1'b0;
        pend_valid = 1'b0;
        step();
        if (!is_mem) begin
            pend_valid = 1'b1; pend_rw = rw; pend_data = a; pend_rd = rd;
        end else begin
            exp_wb_valid = 1'b0;
            exp_req = 1'b1; exp_we = st; exp_addr = a; exp_wdata = b;
            i = 0; done = 1'b0; acked = 1'b0;
            while (!done) begin
                ack_now = (dly >= 0) && (i == dly);
`ifdef MEMCYCLE_TIMEOUT_EN
                to_now = (dly < 0) && (i == TO - 1);
`else
                to_now = 1'b0;
`endif
                mem_ack = ack_now;
                mem_rdata = 16'($urandom);
                if (ack_now) begin
                    if (st) slave_mem[mem_addr[3:0]] = mem_wdata;
                    else    mem_rdata = slave_mem[mem_addr[3:0]];
                end
                exp_stall = !(ack_now || to_now);
                step();
                i++;
                done  = ack_now || to_now;
                acked = ack_now;
                if (i > 1000) begin
                    $display("FAIL access_bound: got %0d cycles expected at most 1000", i);
                    $fatal(1, "access never completed");
                end
            end
            mem_ack = 1'b0;
            if (acked) begin
                pend_valid = 1'b1; pend_rw = rw; pend_rd = rd;
                pend_data  = st ? a : ref_mem[a[3:0]];
                if (st) ref_mem[a[3:0]] = b;
            end else begin
                exp_terr = 1'b1;
            end
        end
    endtask

    task automatic rand_instrs(input int n);
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 9) < 4)
                do_instr(1'b0, 1'b0, 16'($urandom), 16'($urandom), 4'($urandom),
                         1'($urandom), 0, 1'($urandom));
            else
                do_instr(1'($urandom), 1'($urandom_range(0, 2) == 0), 16'($urandom),
                         16'($urandom), 4'($urandom), 1'($urandom),
                         $urandom_range(0, MAX_DLY), 1'($urandom));
        end
    endtask

    task automatic nop();
        do_instr(1'b0, 1'b0, '0, '0, '0, 1'b0, 0, 1'b0);
    endtask

    initial begin
        for (int k = 0; k < 16; k++) begin
            ref_mem[k]   = 16'($urandom);
            slave_mem[k] = ref_mem[k];
        end
        rst = 1'b1;
        aluout = '0; bout = '0; rdout = '0; memread = 1'b0; memwrite = 1'b0;
        regwrite = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        repeat (3) step();
        check("rst_mem_req", mem_req, 0);
        check("rst_wb_regwrite", wb_regwrite, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_timeout_err", timeout_err, 0);
        rst = 1'b0;
        step();
        check_en = 1'b1;

        // ALU pass-through
        stall_cnt = 0;
        do_instr(1'b0, 1'b0, 16'h1234, 16'h0, 4'd3, 1'b1, 0, 1'b0);
        check("alu_wb_data", wb_data, 16'h1234);
        check("alu_wb_rd", wb_rd, 3);
        check("alu_wb_regwrite", wb_regwrite, 1);
        check("alu_stall_cycles", stall_cnt, 0);

        // Load with ack in the 4th ACCESS cycle
        ref_mem[0] = 16'hBEEF; slave_mem[0] = 16'hBEEF;
        stall_cnt = 0;
        do_instr(1'b1, 1'b0, 16'h0040, 16'h0, 4'd5, 1'b1, 3, 1'b0);
        check("load_wb_data", wb_data, 16'hBEEF);
        check("load_wb_rd", wb_rd, 5);
        check("load_wb_regwrite", wb_regwrite, 1);
        check("load_stall_cycles", stall_cnt, 4);

        // Store with ack in the first ACCESS cycle
        stall_cnt = 0;
        do_instr(1'b0, 1'b1, 16'h0010, 16'h00AA, 4'd2, 1'b0, 0, 1'b1);
        check("store_mem_we", seen_we, 1);
        check("store_mem_wdata", seen_wdata, 16'h00AA);
        check("store_wb_regwrite", wb_regwrite, 0);
        check("store_stall_cycles", stall_cnt, 1);

        // Load back the stored word, then an ALU op right behind it
        do_instr(1'b1, 1'b0, 16'h0040, 16'h0, 4'd6, 1'b1, 1, 1'b0);
        check("reload_wb_data", wb_data, 16'h00AA);
        do_instr(1'b0, 1'b0, 16'h5555, 16'h0, 4'd7, 1'b1, 0, 1'b0);
        check("alu_after_load_wb_data", wb_data, 16'h5555);
        check("alu_after_load_wb_rd", wb_rd, 7);

        rand_instrs(150);

`ifdef MEMCYCLE_TIMEOUT_EN
        do_instr(1'b1, 1'b0, 16'h0033, 16'h0, 4'd9, 1'b1, -1, 1'b0);
        check("timeout_err_set", timeout_err, 1);
        check("timeout_wb_regwrite", wb_regwrite, 0);
        check("timeout_mem_req", mem_req, 0);
        rand_instrs(20);
`endif

        // Reset in the middle of an access
        check_en = 1'b0;
        memread = 1'b1; memwrite = 1'b0; aluout = 16'h0123; regwrite = 1'b1; mem_ack = 1'b0;
        step();
        step();
        check("req_before_rst", mem_req, 1);
        rst = 1'b1;
        #1;
        check("rst_async_mem_req", mem_req, 0);
        check("rst_async_wb_regwrite", wb_regwrite, 0);
        check("rst_async_timeout_err", timeout_err, 0);
        aluout = '0; bout = '0; rdout = '0; memread = 1'b0; regwrite = 1'b0;
        step();
        rst = 1'b0;
        mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        #1;
        check("late_ack_stall", stall, 0);
        step();
        mem_ack = 1'b0;
        check("late_ack_mem_req", mem_req, 0);
        check("late_ack_wb_regwrite", wb_regwrite, 0);
        check("late_ack_wb_data", wb_data, 0);
        pend_valid = 1'b0;
        exp_terr   = 1'b0;
        check_en   = 1'b1;

        rand_instrs(150);
        nop();
        nop();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_memory_cycle
